// File: rtl/ai_bus_master.sv
// ai_bus_master: Avalon-MM initiator that loads one shot request into the
// ai accelerator register window, starts it, reads back the result word and
// returns it with a one-cycle valid pulse. Every transfer is guarded by a
// stall timeout that aborts the request with res_err=1.
module ai_bus_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [255:0] fired,
    input  logic [4:0]   ships,
    output logic         res_valid,
    output logic [63:0]  res_data,
    output logic [6:0]   res_index,
    output logic         res_err,
    output logic [2:0]   av_addr,
    output logic         av_write,
    output logic         av_read,
    output logic [63:0]  av_writedata,
    input  logic         av_waitrequest,
    input  logic [63:0]  av_readdata
);

    // Counter must be able to hold TIMEOUT itself.
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t         state;
    logic [2:0]     step;
    logic [CW-1:0]  stall_cnt;
    logic [255:0]   fired_q;
    logic [4:0]     ships_q;

    // Word address of write step s: cells at 1..4, ships at 5, start at 0.
    function automatic logic [2:0] wr_addr(input logic [2:0] s);
        case (s)
            3'd0:    return 3'd1;
            3'd1:    return 3'd2;
            3'd2:    return 3'd3;
            3'd3:    return 3'd4;
            3'd4:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // Write data of step s, taken from the request being issued.
    function automatic logic [63:0] wr_data(input logic [2:0] s,
                                            input logic [255:0] f,
                                            input logic [4:0] sh);
        case (s)
            3'd0:    return f[63:0];
            3'd1:    return f[127:64];
            3'd2:    return f[191:128];
            3'd3:    return f[255:192];
            3'd4:    return {59'd0, sh};
            default: return 64'd1;
        endcase
    endfunction

    // Result index is just the low bits of the held result word.
    assign res_index = res_data[6:0];

    // Request sequencer: all bus strobes and result outputs are registered,
    // so av_waitrequest only ever affects next-cycle state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            step         <= 3'd0;
            stall_cnt    <= '0;
            fired_q      <= '0;
            ships_q      <= '0;
            cmd_ready    <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_err      <= 1'b0;
            av_addr      <= 3'd0;
            av_write     <= 1'b0;
            av_read      <= 1'b0;
            av_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        // First write goes out next cycle straight from the
                        // incoming request; later steps use the latched copy.
                        fired_q      <= fired;
                        ships_q      <= ships;
                        step         <= 3'd0;
                        stall_cnt    <= '0;
                        cmd_ready    <= 1'b0;
                        av_write     <= 1'b1;
                        av_addr      <= wr_addr(3'd0);
                        av_writedata <= wr_data(3'd0, fired, ships);
                        state        <= WR;
                    end
                end
                WR: begin
                    if (!av_waitrequest) begin
                        stall_cnt <= '0;
                        step      <= step + 3'd1;
                        if (step == 3'd5) begin
                            av_write <= 1'b0;
                            av_read  <= 1'b1;
                            av_addr  <= 3'd0;
                            state    <= RD;
                        end else begin
                            av_addr      <= wr_addr(step + 3'd1);
                            av_writedata <= wr_data(step + 3'd1, fired_q, ships_q);
                        end
                    end else if (stall_cnt == CW'(TIMEOUT - 1)) begin
                        // This stalled cycle is number TIMEOUT: abort.
                        stall_cnt <= '0;
                        av_write  <= 1'b0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                RD: begin
                    if (!av_waitrequest) begin
                        stall_cnt <= '0;
                        av_read   <= 1'b0;
                        res_data  <= av_readdata;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else if (stall_cnt == CW'(TIMEOUT - 1)) begin
                        stall_cnt <= '0;
                        av_read   <= 1'b0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                RESP: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    step      <= 3'd0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_bus_master.sv
// tb_ai_bus_master: directed vectors for ai_bus_master against a small
// stalling Avalon slave model, plus hand-written multi-cycle sequences.
module tb_ai_bus_master;

    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] fired;
    logic [4:0]   ships;
    logic         res_valid;
    logic [63:0]  res_data;
    logic [6:0]   res_index;
    logic         res_err;
    logic [2:0]   av_addr;
    logic         av_write;
    logic         av_read;
    logic [63:0]  av_writedata;
    logic         av_waitrequest = 1'b0;
    logic [63:0]  av_readdata;

    ai_bus_master #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .fired(fired), .ships(ships),
        .res_valid(res_valid), .res_data(res_data), .res_index(res_index), .res_err(res_err),
        .av_addr(av_addr), .av_write(av_write), .av_read(av_read),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest), .av_readdata(av_readdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- slave model: stalls chosen transfers ----------------
    logic [2:0] st_wr_addr = 3'd0;
    int st_wr_n = 0, st_rd_n = 0, wr_done = 0, rd_done = 0;

    always @(negedge clock) begin
        if (av_write && av_addr == st_wr_addr && wr_done < st_wr_n) begin
            av_waitrequest = 1'b1; wr_done++;
        end else if (av_read && rd_done < st_rd_n) begin
            av_waitrequest = 1'b1; rd_done++;
        end else begin
            av_waitrequest = 1'b0;
        end
    end

    // ---------------- bus / result monitor ----------------
    typedef struct { logic [2:0] addr; logic [63:0] data; logic rd; int cyc; } xfer_t;
    typedef struct { int rel; int abs_cyc; logic [63:0] data; logic [6:0] idx; logic err; } resp_t;

    xfer_t xlog[$];
    resp_t resp[$];
    int    acc_hist[$];
    int    cyc = 0, acc_last = 0, stab_bad = 0;
    logic  pend = 1'b0;
    logic [68:0] snap;

    always @(posedge clock) begin
        if (pend && (av_write || av_read) && {av_addr, av_writedata, av_write, av_read} != snap)
            stab_bad++;
        if (av_write && av_read) stab_bad++;
        pend = !reset && (av_write || av_read) && av_waitrequest;
        snap = {av_addr, av_writedata, av_write, av_read};
        if (!reset) begin
            if ((av_write || av_read) && !av_waitrequest)
                xlog.push_back('{av_addr, av_read ? av_readdata : av_writedata, av_read, cyc - acc_last});
            if (res_valid)
                resp.push_back('{cyc - acc_last, cyc, res_data, res_index, res_err});
            if (cmd_valid && cmd_ready) begin
                acc_last = cyc;
                acc_hist.push_back(cyc);
            end
        end
        cyc++;
    end

    // Expected i-th transfer of a request (6 writes then the result read).
    function automatic xfer_t exp_x(input logic [255:0] f, input logic [4:0] s,
                                    input logic [63:0] rdv, input int i);
        xfer_t x;
        x.cyc = 0; x.rd = 1'b0;
        if (i < 4) begin x.addr = 3'(i + 1); x.data = f[64*i +: 64]; end
        else if (i == 4) begin x.addr = 3'd5; x.data = {59'd0, s}; end
        else if (i == 5) begin x.addr = 3'd0; x.data = 64'd1; end
        else begin x.addr = 3'd0; x.data = rdv; x.rd = 1'b1; end
        return x;
    endfunction

    task automatic chk_xfers(input string tag, input int x0, input logic [255:0] f,
                             input logic [4:0] s, input logic [63:0] rdv, input int n);
        xfer_t e;
        for (int i = 0; i < n; i++) begin
            e = exp_x(f, s, rdv, i % 7);
            if (x0 + i < xlog.size()) begin
                chk($sformatf("%s.x%0d_addr_rd", tag, i), {xlog[x0+i].addr, xlog[x0+i].rd}, {e.addr, e.rd});
                chk($sformatf("%s.x%0d_data", tag, i), xlog[x0+i].data, e.data);
            end
        end
    endtask

    task automatic wait_acc(input string tag, input int n);
        int k = 0;
        while (acc_hist.size() < n && k < 100) begin @(negedge clock); k++; end
        chk({tag, ".accepted"}, 64'(acc_hist.size() >= n), 64'd1);
    endtask

    task automatic wait_resp(input string tag, input int n);
        int k = 0;
        while (resp.size() < n && k < 200) begin @(negedge clock); k++; end
        chk({tag, ".res_valid_seen"}, 64'(resp.size() >= n), 64'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [255:0] f; logic [4:0] s; logic [63:0] rdata;
        logic [2:0] wa; int wn; int rn;
        int ecyc; logic eerr; logic [63:0] edata; int nx; int nst; logic ccyc;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int x0, r0, a0, sb0;
        st_wr_addr = v.wa; st_wr_n = v.wn; st_rd_n = v.rn; wr_done = 0; rd_done = 0;
        av_readdata = v.rdata;
        x0 = xlog.size(); r0 = resp.size(); a0 = acc_hist.size(); sb0 = stab_bad;
        @(negedge clock);
        cmd_valid = 1'b1; fired = v.f; ships = v.s;
        wait_acc(tag, a0 + 1);
        // Scrambling the inputs after accept shows the request was latched.
        cmd_valid = 1'b0; fired = ~v.f; ships = ~v.s;
        wait_resp(tag, r0 + 1);
        if (resp.size() > r0) begin
            chk({tag, ".res_cycle"}, 64'(resp[r0].rel), 64'(v.ecyc));
            chk({tag, ".res_err"}, 64'(resp[r0].err), 64'(v.eerr));
            chk({tag, ".res_data"}, resp[r0].data, v.edata);
            chk({tag, ".res_index"}, 64'(resp[r0].idx), 64'(v.edata[6:0]));
        end
        chk({tag, ".ready_after"}, {cmd_ready, res_valid, av_write, av_read}, 4'b1000);
        chk({tag, ".n_xfers"}, 64'(xlog.size() - x0), 64'(v.nx));
        chk_xfers(tag, x0, v.f, v.s, v.rdata, v.nx);
        if (v.ccyc)
            for (int i = 0; i < v.nx && x0 + i < xlog.size(); i++)
                chk($sformatf("%s.x%0d_cycle", tag, i), 64'(xlog[x0+i].cyc), 64'(i + 1));
        chk({tag, ".stall_cycles"}, 64'(wr_done + rd_done), 64'(v.nst));
        chk({tag, ".stable_while_stalled"}, 64'(stab_bad - sb0), 64'd0);
    endtask

    vec_t vt[4];
    vec_t vr;

    initial begin
        logic [255:0] f1, f2;
        int x0, r0, a0;

        vt[0] = '{{64'hA, 64'hB, 64'hC, 64'hD}, 5'b11111, 64'd42,
                  3'd0, 0, 0, 8, 1'b0, 64'd42, 7, 0, 1'b1};
        vt[1] = '{{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                   64'h99AA_BBCC_DDEE_FF00, 64'h0F1E_2D3C_4B5A_6978}, 5'b10110,
                  64'hDEAD_BEEF_0000_00E5, 3'd3, 3, 2, 13, 1'b0, 64'hDEAD_BEEF_0000_00E5, 7, 5, 1'b0};
        vt[2] = '{{64'h0, 64'hFFFF, 64'h8000_0000_0000_0001, 64'h1234}, 5'b00001,
                  64'h77, 3'd5, 1000, 0, 13, 1'b1, 64'hDEAD_BEEF_0000_00E5, 4, 8, 1'b0};
        vt[3] = '{{64'hCAFE, 64'hF00D, 64'hBEEF, 64'hFACE}, 5'b00101,
                  64'h0123_4567_89AB_CDEF, 3'd0, 1, 0, 9, 1'b0, 64'h0123_4567_89AB_CDEF, 7, 1, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; fired = '0; ships = '0; av_readdata = '0;
        repeat (3) @(negedge clock);
        chk("reset.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset.strobes", {res_valid, res_err, av_write, av_read}, 4'b0000);
        chk("reset.res_data", res_data, 64'd0);
        chk("reset.av_addr_data", {av_addr, av_writedata}, 67'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset.cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 4; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // cmd_valid pulsed mid-request is ignored
        f1 = {64'h10, 64'h20, 64'h30, 64'h40};
        st_wr_n = 0; st_rd_n = 0; wr_done = 0; rd_done = 0; av_readdata = 64'h55;
        x0 = xlog.size(); r0 = resp.size(); a0 = acc_hist.size();
        @(negedge clock); cmd_valid = 1'b1; fired = f1; ships = 5'b01010;
        wait_acc("ignore", a0 + 1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        cmd_valid = 1'b1; fired = {4{64'hBAD}}; ships = 5'b0;
        @(negedge clock); cmd_valid = 1'b0;
        wait_resp("ignore", r0 + 1);
        repeat (12) @(negedge clock);
        chk("ignore.n_accepts", 64'(acc_hist.size() - a0), 64'd1);
        chk("ignore.n_res_valid", 64'(resp.size() - r0), 64'd1);
        chk("ignore.n_xfers", 64'(xlog.size() - x0), 64'd7);
        chk_xfers("ignore", x0, f1, 5'b01010, 64'h55, 7);

        // reset during the read stall, then a normal request
        st_rd_n = 5; rd_done = 0; av_readdata = 64'h99;
        r0 = resp.size(); a0 = acc_hist.size();
        @(negedge clock); cmd_valid = 1'b1; fired = f1; ships = 5'b00011;
        wait_acc("rst_mid", a0 + 1);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clock);
        chk("rst_mid.read_stalled", {av_read, av_waitrequest}, 2'b11);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_mid.strobes", {res_valid, res_err, av_write, av_read}, 4'b0000);
        chk("rst_mid.res_data", res_data, 64'd0);
        chk("rst_mid.av_addr_data", {av_addr, av_writedata}, 67'd0);
        reset = 1'b0; st_rd_n = 0;
        @(negedge clock);
        chk("rst_mid.cmd_ready_back", 64'(cmd_ready), 64'd1);
        chk("rst_mid.no_res_valid", 64'(resp.size() - r0), 64'd0);
        vr = vt[0];
        vr.rdata = 64'h3; vr.edata = 64'h3;
        run_vec(vr, "after_rst");

        // back-to-back with cmd_valid held high
        f2 = {64'h7, 64'h6, 64'h5, 64'h4};
        st_wr_n = 0; st_rd_n = 0; wr_done = 0; rd_done = 0; av_readdata = 64'h11;
        x0 = xlog.size(); r0 = resp.size(); a0 = acc_hist.size();
        @(negedge clock); cmd_valid = 1'b1; fired = f1; ships = 5'b10000;
        wait_acc("b2b", a0 + 1);
        fired = f2; ships = 5'b00111;
        wait_acc("b2b2", a0 + 2);
        cmd_valid = 1'b0;
        wait_resp("b2b", r0 + 2);
        if (acc_hist.size() >= a0 + 2 && resp.size() >= r0 + 2) begin
            chk("b2b.second_accept", 64'(acc_hist[a0+1] - acc_hist[a0]), 64'd9);
            chk("b2b.res1_cycle", 64'(resp[r0].abs_cyc - acc_hist[a0]), 64'd8);
            chk("b2b.res2_cycle", 64'(resp[r0+1].abs_cyc - acc_hist[a0]), 64'd17);
        end
        chk("b2b.n_xfers", 64'(xlog.size() - x0), 64'd14);
        chk_xfers("b2b.req1", x0, f1, 5'b10000, 64'h11, 7);
        chk_xfers("b2b.req2", x0 + 7, f2, 5'b00111, 64'h11, 7);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passed);
        $fatal(1, "watchdog");
    end

endmodule
